fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, talks req/gnt/rvalid to imem, buffers words.
// Optional same-cycle response bypass when the queue is empty: FETCH_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc_plus_four,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          waiting;
  logic          discard;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [63:0]   mem [DEPTH];

  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;
  logic          fifo_nz;
  logic [AW+1:0] credits;
  logic [31:0]   resp_pc4;
  logic          unused_pc_lo;

  assign unused_pc_lo = ^redirect_pc[1:0];

  // Outstanding request counts against queue space so a response always fits.
  assign credits  = {1'b0, count} + {{(AW+1){1'b0}}, waiting};
  assign imem_req = reset && !redirect_valid
                 && (!waiting || imem_rvalid)
                 && (credits < LIMIT);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && waiting
                  && !discard && !redirect_valid;
  assign resp_pc4  = req_pc + 32'd4;
  assign fifo_nz   = (count != '0);
  assign pop       = fifo_nz && out_ready && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = resp && !fifo_nz;
  assign out_valid = fifo_nz || bypass;
  assign out_instruction =
    bypass ? imem_rdata : mem[rd_ptr][63:32];
  assign out_pc_plus_four =
    bypass ? resp_pc4 : mem[rd_ptr][31:0];
  assign push = resp && !(bypass && out_ready);
`else
  assign out_valid        = fifo_nz;
  assign out_instruction  = mem[rd_ptr][63:32];
  assign out_pc_plus_four = mem[rd_ptr][31:0];
  assign push             = resp;
`endif

  // Fetch PC, outstanding-request tracking and stale-response discard.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      waiting  <= 1'b0;
      discard  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      waiting  <= waiting && !imem_rvalid;
      discard  <= waiting && !imem_rvalid;
    end else begin
      if (imem_rvalid && waiting) begin
        waiting <= 1'b0;
        discard <= 1'b0;
      end
      if (grant) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
        waiting  <= 1'b1;
      end
    end
  end

  // Queue pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Entry storage: {instruction, pc+4}.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {imem_rdata, resp_pc4};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios, reactive imem responder,
// and a queue-based reference model compared every cycle.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [31:0] out_pc_plus_four;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_checks = 0;
  int n_fail = 0;
  int lat = 1;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_pc_plus_four(out_pc_plus_four),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      tick(1);
      #1;
      k++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s: out_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic restart();
    tick(1);
    reset = 1'b0;
    imem_gnt = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    lat = 1;
    tick(6);
    reset = 1'b1;
  endtask

  // imem responder: one response lat cycles after each grant.
  initial begin : imem_model
    bit fire;
    bit pend;
    int cnt;
    logic [31:0] fa;
    logic [31:0] pa;
    pend = 0;
    cnt = 0;
    pa = '0;
    forever begin
      @(negedge clock);
      fire = imem_req && imem_gnt;
      fa = imem_addr;
      @(posedge clock);
      #1;
      imem_rvalid = 1'b0;
      if (fire) begin
        pend = 1;
        cnt = lat;
        pa = fa;
      end
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata = word(pa);
          pend = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Reference model: queue of {instr, pc+4}; checked on every falling edge.
  initial begin : ref_model
    logic [63:0] q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_req_pc;
    bit m_wait;
    bit m_disc;
    bit e_req;
    bit resp;
    bit byp;
    bit e_valid;
    logic [63:0] e_ent;
    int n;
    m_fetch = '0;
    m_req_pc = '0;
    m_wait = 0;
    m_disc = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        q.delete();
        m_fetch = 32'h0;
        m_req_pc = '0;
        m_wait = 0;
        m_disc = 0;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_instr", out_instruction, 32'h0);
        chk("rst_pc4", out_pc_plus_four, 32'h0);
      end else begin
        n = q.size();
        e_req = !redirect_valid && (!m_wait || imem_rvalid)
             && (n + int'(m_wait) < DEPTH);
        resp = imem_rvalid && m_wait && !m_disc && !redirect_valid;
        byp = 0;
`ifdef FETCH_BYPASS_EN
        byp = resp && (n == 0);
`endif
        e_valid = (n != 0) || byp;
        e_ent = (n != 0) ? q[0] : {imem_rdata, m_req_pc + 32'd4};
        chk("m_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("m_addr", imem_addr, m_fetch);
        chk("m_valid", {31'b0, out_valid}, {31'b0, e_valid});
        if (e_valid) begin
          chk("m_instr", out_instruction, e_ent[63:32]);
          chk("m_pc4", out_pc_plus_four, e_ent[31:0]);
        end
        if (n != 0 && out_ready && !redirect_valid) void'(q.pop_front());
        if (resp && !(byp && out_ready))
          q.push_back({imem_rdata, m_req_pc + 32'd4});
        if (redirect_valid) begin
          q.delete();
          m_fetch = {redirect_pc[31:2], 2'b00};
          m_disc = m_wait && !imem_rvalid;
          m_wait = m_wait && !imem_rvalid;
        end else begin
          if (imem_rvalid && m_wait) begin
            m_wait = 0;
            m_disc = 0;
          end
          if (e_req && imem_gnt) begin
            m_req_pc = m_fetch;
            m_fetch = m_fetch + 32'd4;
            m_wait = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : directed
    // Reset state, then first fetch and latency.
    #3;
    chk("t1_rst_req", {31'b0, imem_req}, 32'h0);
    chk("t1_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("t1_rst_instr", out_instruction, 32'h0);
    tick(1);
    reset = 1'b1;
    imem_gnt = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    tick(1);
    #1;
`ifdef FETCH_BYPASS_EN
    chk("t1_byp_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_byp_instr", out_instruction, 32'h8C01_0004);
    chk("t1_byp_pc4", out_pc_plus_four, 32'h4);
`else
    chk("t1_lat_valid0", {31'b0, out_valid}, 32'h0);
    tick(1);
    #1;
    chk("t1_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_instr", out_instruction, 32'h8C01_0004);
    chk("t1_pc4", out_pc_plus_four, 32'h4);
`endif

    // Fill to DEPTH with out_ready low, then drain in order.
    restart();
    imem_gnt = 1'b1;
    tick(5);
    #1;
    chk("t2_full_req", {31'b0, imem_req}, 32'h0);
    chk("t2_full_addr", imem_addr, 32'h10);
    chk("t2_full_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    #1;
    chk("t2_d0", out_pc_plus_four, 32'h4);
    tick(1);
    #1;
    chk("t2_d1", out_pc_plus_four, 32'h8);
    chk("t2_resume_req", {31'b0, imem_req}, 32'h1);
    chk("t2_resume_addr", imem_addr, 32'h10);
    tick(1);
    #1;
    chk("t2_d2", out_pc_plus_four, 32'hC);
    tick(1);
    #1;
    chk("t2_d3", out_pc_plus_four, 32'h10);

    // Redirect while a request is in flight: stale response dropped.
    restart();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    #1;
    chk("t3_redir_req", {31'b0, imem_req}, 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    lat = 3;
    imem_gnt = 1'b1;
    #1;
    chk("t3_req8", imem_addr, 32'h8);
    tick(1);
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    tick(1);
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    #1;
    chk("t3_disc_req", {31'b0, imem_req}, 32'h0);
    tick(1);
    #1;
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_new_req", {31'b0, imem_req}, 32'h1);
    chk("t3_stale_v", {31'b0, out_valid}, 32'h0);
    tick(1);
    #1;
    chk("t3_stale_v2", {31'b0, out_valid}, 32'h0);
    wait_valid("t3_wait");
    chk("t3_pc4", out_pc_plus_four, 32'h104);
    chk("t3_instr", out_instruction, word(32'h100));

    // Redirect and out_ready together with two entries queued.
    restart();
    imem_gnt = 1'b1;
    tick(3);
    #1;
    chk("t4_valid", {31'b0, out_valid}, 32'h1);
    chk("t4_head", out_pc_plus_four, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    out_ready = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("t4_flush_v", {31'b0, out_valid}, 32'h0);
    chk("t4_addr", imem_addr, 32'h200);

    // Grant stall holds the request; PC wraps at 2^32.
    restart();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_hold_req", {31'b0, imem_req}, 32'h1);
      chk("t5_hold_addr", imem_addr, 32'hFFFF_FFFC);
      tick(1);
    end
    imem_gnt = 1'b1;
    tick(1);
    imem_gnt = 1'b0;
    #1;
    chk("t5_wrap", imem_addr, 32'h0);
    wait_valid("t5_wait");
    chk("t5_pc4", out_pc_plus_four, 32'h0);

    // Asynchronous reset mid-wait; late response ignored afterwards.
    restart();
    imem_gnt = 1'b1;
    tick(1);
    lat = 4;
    tick(1);
    imem_gnt = 1'b0;
    #1;
    chk("t6_pre_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b0;
    #1;
    chk("t6_async_req", {31'b0, imem_req}, 32'h0);
    chk("t6_async_valid", {31'b0, out_valid}, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(3);
    #1;
    chk("t6_late_v", {31'b0, out_valid}, 32'h0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req", {31'b0, imem_req}, 32'h1);
    lat = 1;
    imem_gnt = 1'b1;
    out_ready = 1'b1;
    wait_valid("t6_wait");
    chk("t6_instr", out_instruction, 32'h8C01_0004);
    chk("t6_pc4", out_pc_plus_four, 32'h4);

    imem_gnt = 1'b0;
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
